// File: rtl/csense_adc_responder.sv
// csense_adc_responder: device-side model of the two current-sense SPI ADCs on the csense port.
// Each frame serves a stale-tagged conversion word and captures the master's leading command bits.
module csense_adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 24,
    parameter int CMD_BITS    = 8
) (
    input  logic                 clk50_clk,
    input  logic                 rst_reset_n,
    input  logic [1:0]           csense_cs_n_i,
    input  logic                 csense_sck_i,
    input  logic                 csense_sdi_i,
    output logic                 csense_sdo_o,
    input  logic                 load_valid_i,
    input  logic                 load_dev_i,
    input  logic [DATA_BITS-1:0] load_data_i,
    output logic                 cmd_valid_o,
    output logic                 cmd_dev_o,
    output logic [CMD_BITS-1:0]  cmd_data_o,
    output logic                 frame_err_o
);

    localparam int         FRAME_BITS = DATA_BITS + 8;
    localparam int         PAD_BITS   = FRAME_BITS - DATA_BITS - 2;
    localparam logic [5:0] FRAME_CNT  = 6'(FRAME_BITS);
    localparam logic [5:0] CMD_CNT    = 6'(CMD_BITS);
    localparam logic [5:0] CNT_MAX    = 6'd63;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]           sync_q [SYNC_STAGES];
    logic [3:0]           pins_s;
    logic [2:0]           prev_q;
    logic [1:0]           cs_s;
    logic [1:0]           cs_fall;
    logic [1:0]           cs_rise;
    logic                 sck_rise;
    logic                 sck_fall;
    logic                 sdi_s;
    logic                 other_fall;
    logic                 sel_rise;
    logic                 snap;
    logic                 snap_dev;

    logic [FRAME_BITS-1:0] tx_sr;
    logic [CMD_BITS-1:0]   rx_sr;
    logic [5:0]            bit_cnt;
    logic                  dev_q;
    logic [DATA_BITS-1:0]  hold [2];
    logic [1:0]            stale;

    // Synchronisers are left unreset so they keep tracking the pins during reset;
    // WAIT_IDLE then refuses to decode a frame that was already open.
    always_ff @(posedge clk50_clk) begin
        sync_q[0] <= {csense_sdi_i, csense_sck_i, csense_cs_n_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        prev_q <= pins_s[2:0];
    end

    assign pins_s     = sync_q[SYNC_STAGES-1];
    assign cs_s       = pins_s[1:0];
    assign sdi_s      = pins_s[3];
    assign cs_fall    = prev_q[1:0] & ~cs_s;
    assign cs_rise    = ~prev_q[1:0] & cs_s;
    assign sck_rise   = pins_s[2] & ~prev_q[2];
    assign sck_fall   = ~pins_s[2] & prev_q[2];
    assign other_fall = dev_q ? cs_fall[0] : cs_fall[1];
    assign sel_rise   = dev_q ? cs_rise[1] : cs_rise[0];
    assign snap_dev   = cs_fall[1];

    always_ff @(posedge clk50_clk) begin
        if (!rst_reset_n) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        snap       = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (&cs_s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (~|cs_s) begin
                    state_next = ERR;
                end else if (cs_fall[0] ^ cs_fall[1]) begin
                    state_next = SHIFT;
                    snap       = 1'b1;
                end
            end
            SHIFT: begin
                if (other_fall) begin
                    state_next = ERR;
                end else if (sel_rise) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ERR: begin
                if (&cs_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = WAIT_IDLE;
            end
        endcase
    end

    // A load in the snapshot cycle is written after the stale mark, so the new value stays fresh.
    always_ff @(posedge clk50_clk) begin
        if (!rst_reset_n) begin
            hold[0] <= '0;
            hold[1] <= '0;
            stale   <= 2'b11;
        end else begin
            if (snap) begin
                stale[snap_dev] <= 1'b1;
            end
            if (load_valid_i) begin
                hold[load_dev_i]  <= load_data_i;
                stale[load_dev_i] <= 1'b0;
            end
        end
    end

    // Shift registers fill with ones so sdo idles high once the LSB has gone out.
    always_ff @(posedge clk50_clk) begin
        if (!rst_reset_n) begin
            tx_sr   <= '1;
            rx_sr   <= '0;
            bit_cnt <= '0;
            dev_q   <= 1'b0;
        end else if (snap) begin
            tx_sr   <= {stale[snap_dev], snap_dev, {PAD_BITS{1'b0}}, hold[snap_dev]};
            rx_sr   <= '0;
            bit_cnt <= '0;
            dev_q   <= snap_dev;
        end else if (state == SHIFT) begin
            if (sck_rise) begin
                if (bit_cnt < CMD_CNT) begin
                    rx_sr <= {rx_sr[CMD_BITS-2:0], sdi_s};
                end
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
            if (sck_fall) begin
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk50_clk) begin
        if (!rst_reset_n) begin
            cmd_valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            cmd_dev_o   <= 1'b0;
            cmd_data_o  <= '0;
        end else begin
            cmd_valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            if (state == DONE) begin
                if (bit_cnt == FRAME_CNT) begin
                    cmd_valid_o <= 1'b1;
                    cmd_data_o  <= rx_sr;
                    cmd_dev_o   <= dev_q;
                end else begin
                    frame_err_o <= 1'b1;
                end
            end
            if ((state == ERR) && (&cs_s)) begin
                frame_err_o <= 1'b1;
            end
        end
    end

    assign csense_sdo_o = (state == SHIFT) ? tx_sr[FRAME_BITS-1] : 1'b1;

endmodule

// File: tb/tb_csense_adc_responder.sv
// tb_csense_adc_responder: SPI master bench for csense_adc_responder.
// Expected frame words come from a per-device hold/stale model driven alongside the stimulus.
module tb_csense_adc_responder;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_BITS   = 24;
    localparam int CMD_BITS    = 8;
    localparam int FRAME_BITS  = DATA_BITS + 8;
    localparam int PAD_BITS    = FRAME_BITS - DATA_BITS - 2;
    localparam int HALF        = 4;

    logic                 clk50_clk = 1'b0;
    logic                 rst_reset_n;
    logic [1:0]           csense_cs_n_i;
    logic                 csense_sck_i;
    logic                 csense_sdi_i;
    logic                 csense_sdo_o;
    logic                 load_valid_i;
    logic                 load_dev_i;
    logic [DATA_BITS-1:0] load_data_i;
    logic                 cmd_valid_o;
    logic                 cmd_dev_o;
    logic [CMD_BITS-1:0]  cmd_data_o;
    logic                 frame_err_o;

    int n_checks   = 0;
    int n_fail     = 0;
    int valid_seen = 0;
    int err_seen   = 0;

    logic [DATA_BITS-1:0] m_hold  [2];
    logic                 m_stale [2];

    csense_adc_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .DATA_BITS  (DATA_BITS),
        .CMD_BITS   (CMD_BITS)
    ) dut (
        .clk50_clk    (clk50_clk),
        .rst_reset_n  (rst_reset_n),
        .csense_cs_n_i(csense_cs_n_i),
        .csense_sck_i (csense_sck_i),
        .csense_sdi_i (csense_sdi_i),
        .csense_sdo_o (csense_sdo_o),
        .load_valid_i (load_valid_i),
        .load_dev_i   (load_dev_i),
        .load_data_i  (load_data_i),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_dev_o    (cmd_dev_o),
        .cmd_data_o   (cmd_data_o),
        .frame_err_o  (frame_err_o)
    );

    always #10 clk50_clk = ~clk50_clk;

    always @(negedge clk50_clk) begin
        if (cmd_valid_o === 1'b1) valid_seen++;
        if (frame_err_o === 1'b1) err_seen++;
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_hold[d]  = '0;
            m_stale[d] = 1'b1;
        end
    endtask

    task automatic model_load(input logic dev, input logic [DATA_BITS-1:0] data);
        m_hold[dev]  = data;
        m_stale[dev] = 1'b0;
    endtask

    // Starting a frame on a device hands out its word and makes the held value stale.
    task automatic model_frame_start(input logic dev, output logic [FRAME_BITS-1:0] word);
        word = {m_stale[dev], dev, {PAD_BITS{1'b0}}, m_hold[dev]};
        m_stale[dev] = 1'b1;
    endtask

    task automatic do_load(input logic dev, input logic [DATA_BITS-1:0] data);
        @(negedge clk50_clk);
        load_valid_i = 1'b1;
        load_dev_i   = dev;
        load_data_i  = data;
        @(negedge clk50_clk);
        load_valid_i = 1'b0;
        model_load(dev, data);
    endtask

    task automatic apply_frame(input logic dev, input int nedges, input logic [FRAME_BITS-1:0] mosi,
                               input int reset_at, input logic load_at_fall,
                               input logic [DATA_BITS-1:0] load_val,
                               output logic [FRAME_BITS-1:0] miso, output logic sdo_after,
                               output int dv, output int de);
        int v0;
        int e0;
        v0   = valid_seen;
        e0   = err_seen;
        miso = '1;
        @(negedge clk50_clk);
        csense_cs_n_i[dev] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk50_clk);
            if (load_at_fall && k == SYNC_STAGES) begin
                load_valid_i = 1'b1;
                load_dev_i   = dev;
                load_data_i  = load_val;
            end else begin
                load_valid_i = 1'b0;
            end
        end
        for (int i = 0; i < nedges; i++) begin
            if (i == reset_at) begin
                rst_reset_n = 1'b0;
                repeat (3) @(negedge clk50_clk);
                rst_reset_n = 1'b1;
            end
            csense_sdi_i = 1'b0;
            if (i < FRAME_BITS) csense_sdi_i = mosi[FRAME_BITS-1-i];
            repeat (HALF) @(negedge clk50_clk);
            if (i < FRAME_BITS) miso[FRAME_BITS-1-i] = csense_sdo_o;
            csense_sck_i = 1'b1;
            repeat (HALF) @(negedge clk50_clk);
            csense_sck_i = 1'b0;
        end
        repeat (HALF) @(negedge clk50_clk);
        sdo_after = csense_sdo_o;
        csense_cs_n_i[dev] = 1'b1;
        repeat (8) @(negedge clk50_clk);
        dv = valid_seen - v0;
        de = err_seen - e0;
    endtask

    task automatic test_reset();
        rst_reset_n   = 1'b0;
        csense_cs_n_i = 2'b11;
        csense_sck_i  = 1'b0;
        csense_sdi_i  = 1'b0;
        load_valid_i  = 1'b0;
        load_dev_i    = 1'b0;
        load_data_i   = '0;
        repeat (5) @(negedge clk50_clk);
        n_checks++;
        if (csense_sdo_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sdo: got %b expected 1", csense_sdo_o); end
        n_checks++;
        if (cmd_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid_o); end
        n_checks++;
        if (frame_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        n_checks++;
        if (cmd_dev_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_dev: got %b expected 0", cmd_dev_o); end
        n_checks++;
        if (cmd_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_cmd_data: got %h expected 0", cmd_data_o); end
        rst_reset_n = 1'b1;
        model_reset();
        repeat (6) @(negedge clk50_clk);
    endtask

    task automatic test_basic_frame();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic sdo_after;
        int dv, de;
        do_load(1'b0, 24'hABCDEF);
        mosi = {8'hA5, DATA_BITS'($urandom)};
        model_frame_start(1'b0, exp_w);
        apply_frame(1'b0, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL basic_word: got %h expected %h", miso, exp_w); end
        n_checks++;
        if (dv != 1 || de != 0) begin n_fail++; $display("[TB] FAIL basic_pulses: got valid=%0d err=%0d expected 1/0", dv, de); end
        n_checks++;
        if (cmd_data_o !== 8'hA5) begin n_fail++; $display("[TB] FAIL basic_cmd: got %h expected a5", cmd_data_o); end
        n_checks++;
        if (cmd_dev_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_dev: got %b expected 0", cmd_dev_o); end
        n_checks++;
        if (sdo_after !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_sdo_after_lsb: got %b expected 1", sdo_after); end
    endtask

    task automatic test_stale_frame();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic sdo_after;
        int dv, de;
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b0, exp_w);
        apply_frame(1'b0, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL stale_word: got %h expected %h", miso, exp_w); end
        n_checks++;
        if (cmd_data_o !== mosi[FRAME_BITS-1 -: CMD_BITS]) begin
            n_fail++; $display("[TB] FAIL stale_cmd: got %h expected %h", cmd_data_o, mosi[FRAME_BITS-1 -: CMD_BITS]);
        end
    endtask

    task automatic test_dev1();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic sdo_after;
        int dv, de;
        do_load(1'b1, 24'h123456);
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b1, exp_w);
        apply_frame(1'b1, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL dev1_word: got %h expected %h", miso, exp_w); end
        n_checks++;
        if (dv != 1 || de != 0) begin n_fail++; $display("[TB] FAIL dev1_pulses: got valid=%0d err=%0d expected 1/0", dv, de); end
        n_checks++;
        if (cmd_dev_o !== 1'b1) begin n_fail++; $display("[TB] FAIL dev1_dev: got %b expected 1", cmd_dev_o); end
        n_checks++;
        if (cmd_data_o !== mosi[FRAME_BITS-1 -: CMD_BITS]) begin
            n_fail++; $display("[TB] FAIL dev1_cmd: got %h expected %h", cmd_data_o, mosi[FRAME_BITS-1 -: CMD_BITS]);
        end
    endtask

    task automatic test_short_frame();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic sdo_after;
        int dv, de;
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b0, exp_w);
        apply_frame(1'b0, 20, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso[FRAME_BITS-1 -: 20] !== exp_w[FRAME_BITS-1 -: 20]) begin
            n_fail++; $display("[TB] FAIL short_bits: got %h expected %h", miso[FRAME_BITS-1 -: 20], exp_w[FRAME_BITS-1 -: 20]);
        end
        n_checks++;
        if (dv != 0 || de != 1) begin n_fail++; $display("[TB] FAIL short_pulses: got valid=%0d err=%0d expected 0/1", dv, de); end
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b0, exp_w);
        apply_frame(1'b0, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL after_short_word: got %h expected %h", miso, exp_w); end
        n_checks++;
        if (dv != 1 || de != 0) begin n_fail++; $display("[TB] FAIL after_short_pulses: got valid=%0d err=%0d expected 1/0", dv, de); end
    endtask

    task automatic test_both_cs();
        int v0, e0, bad;
        v0  = valid_seen;
        e0  = err_seen;
        bad = 0;
        @(negedge clk50_clk);
        csense_cs_n_i = 2'b00;
        repeat (6) @(negedge clk50_clk);
        for (int i = 0; i < 8; i++) begin
            csense_sdi_i = 1'($urandom);
            repeat (HALF) @(negedge clk50_clk);
            if (csense_sdo_o !== 1'b1) bad++;
            csense_sck_i = 1'b1;
            repeat (HALF) @(negedge clk50_clk);
            if (csense_sdo_o !== 1'b1) bad++;
            csense_sck_i = 1'b0;
        end
        n_checks++;
        if (valid_seen != v0 || err_seen != e0) begin
            n_fail++; $display("[TB] FAIL both_cs_early_pulse: got valid=%0d err=%0d expected 0/0", valid_seen - v0, err_seen - e0);
        end
        csense_cs_n_i = 2'b11;
        repeat (8) @(negedge clk50_clk);
        n_checks++;
        if (bad != 0) begin n_fail++; $display("[TB] FAIL both_cs_sdo: got %0d low samples expected 0", bad); end
        n_checks++;
        if (valid_seen - v0 != 0 || err_seen - e0 != 1) begin
            n_fail++; $display("[TB] FAIL both_cs_pulses: got valid=%0d err=%0d expected 0/1", valid_seen - v0, err_seen - e0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic sdo_after;
        int dv, de;
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b0, exp_w);
        for (int i = 10; i < FRAME_BITS; i++) exp_w[FRAME_BITS-1-i] = 1'b1;
        apply_frame(1'b0, FRAME_BITS, mosi, 10, 1'b0, '0, miso, sdo_after, dv, de);
        model_reset();
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL midreset_word: got %h expected %h", miso, exp_w); end
        n_checks++;
        if (dv != 0 || de != 0) begin n_fail++; $display("[TB] FAIL midreset_pulses: got valid=%0d err=%0d expected 0/0", dv, de); end
        n_checks++;
        if (sdo_after !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_sdo: got %b expected 1", sdo_after); end
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b1, exp_w);
        apply_frame(1'b1, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL post_reset_word: got %h expected %h", miso, exp_w); end
        n_checks++;
        if (dv != 1 || cmd_data_o !== mosi[FRAME_BITS-1 -: CMD_BITS] || cmd_dev_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL post_reset_cmd: got valid=%0d cmd=%h dev=%b expected 1/%h/1",
                               dv, cmd_data_o, cmd_dev_o, mosi[FRAME_BITS-1 -: CMD_BITS]);
        end
    endtask

    task automatic test_load_at_fall();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic [DATA_BITS-1:0] new_val;
        logic sdo_after;
        int dv, de;
        do_load(1'b0, DATA_BITS'($urandom));
        new_val = DATA_BITS'($urandom);
        mosi    = FRAME_BITS'($urandom);
        model_frame_start(1'b0, exp_w);
        model_load(1'b0, new_val);
        apply_frame(1'b0, FRAME_BITS, mosi, -1, 1'b1, new_val, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL load_at_fall_old: got %h expected %h", miso, exp_w); end
        mosi = FRAME_BITS'($urandom);
        model_frame_start(1'b0, exp_w);
        apply_frame(1'b0, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL load_at_fall_new: got %h expected %h", miso, exp_w); end
    endtask

    task automatic test_random();
        logic [FRAME_BITS-1:0] exp_w, mosi, miso;
        logic sdo_after, dev;
        int dv, de;
        for (int n = 0; n < 6; n++) begin
            dev = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_load(dev, DATA_BITS'($urandom));
            mosi = FRAME_BITS'($urandom);
            model_frame_start(dev, exp_w);
            apply_frame(dev, FRAME_BITS, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
            n_checks++;
            if (miso !== exp_w) begin n_fail++; $display("[TB] FAIL random_word[%0d]: got %h expected %h", n, miso, exp_w); end
            n_checks++;
            if (dv != 1 || de != 0 || cmd_dev_o !== dev || cmd_data_o !== mosi[FRAME_BITS-1 -: CMD_BITS]) begin
                n_fail++; $display("[TB] FAIL random_cmd[%0d]: got valid=%0d err=%0d dev=%b cmd=%h expected 1/0/%b/%h",
                                   n, dv, de, cmd_dev_o, cmd_data_o, dev, mosi[FRAME_BITS-1 -: CMD_BITS]);
            end
        end
        dev  = 1'($urandom_range(0, 1));
        mosi = FRAME_BITS'($urandom);
        model_frame_start(dev, exp_w);
        apply_frame(dev, FRAME_BITS + 2, mosi, -1, 1'b0, '0, miso, sdo_after, dv, de);
        n_checks++;
        if (dv != 0 || de != 1) begin n_fail++; $display("[TB] FAIL overlong_pulses: got valid=%0d err=%0d expected 0/1", dv, de); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stale_frame();
        test_dev1();
        test_short_frame();
        test_both_cs();
        test_reset_midframe();
        test_load_at_fall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
